// File: rtl/mdu_ctrl.sv
// mdu_ctrl: EX-stage multiply/divide controller owning HI/LO.
// Results are computed when the operation is accepted and held in pending
// registers. A down-counter models the unit's occupancy, and the pending
// values are committed to HI/LO when the counter reaches its last cycle.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        Stall
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next, lo_reg, lo_next;
  logic [31:0] pend_hi_reg, pend_hi_next, pend_lo_reg, pend_lo_next;
  // Cleared on divide by zero so that the completion leaves HI/LO untouched.
  logic        pend_wr_reg, pend_wr_next;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Sign-extended operands produce the correct low 64 bits of the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed division is done on magnitudes. This avoids the overflow case of
  // most-negative / -1 and keeps truncation toward zero explicit.
  assign a_mag = A[31] ? (~A + 32'd1) : A;
  assign b_mag = B[31] ? (~B + 32'd1) : B;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign q_s   = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = A[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u   = (B == 32'd0) ? 32'd0 : A / B;
  assign r_u   = (B == 32'd0) ? 32'd0 : A % B;

  // State register and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      pend_wr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      pend_wr_reg <= pend_wr_next;
    end
  end

  // Next-state logic: accept operations in IDLE and count down in BUSY.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    pend_wr_next = pend_wr_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0: begin
              pend_hi_next = prod_s[63:32];
              pend_lo_next = prod_s[31:0];
              pend_wr_next = 1'b1;
              cnt_next     = 4'(MULT_CYCLES);
              state_next   = BUSY;
            end
            3'd1: begin
              pend_hi_next = prod_u[63:32];
              pend_lo_next = prod_u[31:0];
              pend_wr_next = 1'b1;
              cnt_next     = 4'(MULT_CYCLES);
              state_next   = BUSY;
            end
            3'd2: begin
              pend_hi_next = r_s;
              pend_lo_next = q_s;
              pend_wr_next = (B != 32'd0);
              cnt_next     = 4'(DIV_CYCLES);
              state_next   = BUSY;
            end
            3'd3: begin
              pend_hi_next = r_u;
              pend_lo_next = q_u;
              pend_wr_next = (B != 32'd0);
              cnt_next     = 4'(DIV_CYCLES);
              state_next   = BUSY;
            end
            3'd4:    hi_next = A;
            3'd5:    lo_next = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_reg <= 4'd1) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
          if (pend_wr_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy  = (state_reg == BUSY);
  assign hi    = hi_reg;
  assign lo    = lo_reg;
  assign Stall = md_use && (start || busy);

endmodule
